// File: rtl/sprite_actor_if.sv
// Draw-side bus of the sprite actor: the draw request, the sprite-sheet ROM port
// and the pixel stream towards the frame buffer.
//
// Handshake: draw_start is a one-cycle request that is taken only while
// draw_busy is 0. draw_busy rises the cycle after an accepted draw_start and
// stays high until the draw completes. draw_done is a one-cycle pulse in the
// cycle draw_busy falls. rom_data must carry the colour for the rom_addr of the
// previous cycle. A pixel is transferred in every cycle with draw_we=1. There
// is no back-pressure.
interface sprite_actor_if #(
    parameter int ADDR_W = 12
);
    logic              draw_start;
    logic [ADDR_W-1:0] rom_addr;
    logic [5:0]        rom_data;
    logic [8:0]        draw_x;
    logic [7:0]        draw_y;
    logic [5:0]        draw_color;
    logic              draw_we;
    logic              draw_busy;
    logic              draw_done;

    modport master (
        input  draw_start, rom_data,
        output rom_addr, draw_x, draw_y, draw_color, draw_we, draw_busy, draw_done
    );

    modport slave (
        output draw_start, rom_data,
        input  rom_addr, draw_x, draw_y, draw_color, draw_we, draw_busy, draw_done
    );
endinterface

// File: rtl/sprite_actor.sv
// Sprite actor: keeps a sprite's position, facing, walk frame and attack state,
// and on request streams the sprite's pixels from the sprite-sheet ROM to the
// frame buffer, skipping transparent pixels.
module sprite_actor #(
    parameter int          SPR_W    = 16,
    parameter int          SPR_H    = 16,
    parameter int          MAP_W    = 256,
    parameter int          MAP_H    = 176,
    parameter int          STEP     = 1,
    parameter int          N_FRAMES = 2,
    parameter int          ATK_LEN  = 4,
    parameter int          INIT_X   = 127,
    parameter int          INIT_Y   = 88,
    parameter logic [5:0]  TRANSP   = 6'h3F
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       init,
    input  logic       apply_action,
    input  logic [2:0] action,
    input  logic [3:0] blocked,
    output logic [8:0] x_pos,
    output logic [7:0] y_pos,
    output logic [1:0] facing,
    output logic       attacking,
    output logic [1:0] dbg_state,
    sprite_actor_if.master bus
);
    localparam int COL_W  = $clog2(SPR_W);
    localparam int ROW_W  = $clog2(SPR_H);
    localparam int FRM_W  = $clog2(N_FRAMES);
    localparam int PIX_W  = ROW_W + COL_W;
    localparam int ADDR_W = 2 + 1 + FRM_W + PIX_W;
    localparam int ATK_W  = $clog2(ATK_LEN + 1);

    localparam logic [8:0] X_MAX  = 9'(MAP_W - SPR_W);
    localparam logic [7:0] Y_MAX  = 8'(MAP_H - SPR_H);
    localparam logic [8:0] STEP_X = 9'(STEP);
    localparam logic [7:0] STEP_Y = 8'(STEP);
    // A zero step never moves the sprite, so it must never animate it either.
    localparam bit         MOVES  = (STEP > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PIX_W-1:0]   pix_q;
    logic [8:0]         x_lat, draw_x_q;
    logic [7:0]         y_lat, draw_y_q;
    logic               pix_valid, done_q;
    logic [FRM_W-1:0]   frame_q, frame_eff;
    logic [ATK_W-1:0]   atk_cnt_q;
    logic [ADDR_W-1:0]  rom_addr_w;
    logic               last_pix, act_ok;

    assign last_pix  = (pix_q == {PIX_W{1'b1}});
    // Position is frozen while a draw is in flight; init overrides any action.
    assign act_ok    = apply_action && !init && (state_q == IDLE);
    assign frame_eff = attacking ? '0 : frame_q;
    assign dbg_state = state_q;

    // Draw sequencer next state; init aborts any draw and blocks a new one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.draw_start) state_d = FETCH;
            FETCH:   if (last_pix) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (init) state_d = IDLE;
    end

    // Draw sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Pixel counter, position latch and the one-stage pixel output pipeline.
    always_ff @(posedge clock) begin
        if (reset || init) begin
            pix_q     <= '0;
            x_lat     <= '0;
            y_lat     <= '0;
            pix_valid <= 1'b0;
            draw_x_q  <= '0;
            draw_y_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            pix_valid <= (state_q == FETCH);
            done_q    <= (state_q == FLUSH);
            if (state_q == FETCH) begin
                draw_x_q <= x_lat + 9'(pix_q[COL_W-1:0]);
                draw_y_q <= y_lat + 8'(pix_q[PIX_W-1:COL_W]);
                pix_q    <= pix_q + 1'b1;
            end
            if (state_q == IDLE && bus.draw_start) begin
                pix_q <= '0;
                x_lat <= x_pos;
                y_lat <= y_pos;
            end
        end
    end

    // Actor state: movement with clamping, facing, walk frame and attack timer.
    always_ff @(posedge clock) begin
        if (reset || init) begin
            x_pos     <= 9'(INIT_X);
            y_pos     <= 8'(INIT_Y);
            facing    <= 2'd1;
            attacking <= 1'b0;
            frame_q   <= '0;
            atk_cnt_q <= '0;
        end else if (act_ok) begin
            if (attacking) begin
                atk_cnt_q <= atk_cnt_q - 1'b1;
                if (atk_cnt_q <= ATK_W'(1)) attacking <= 1'b0;
            end else begin
                case (action)
                    3'd1: begin
                        attacking <= 1'b1;
                        atk_cnt_q <= ATK_W'(ATK_LEN);
                    end
                    3'd2: begin
                        facing <= 2'd0;
                        if (MOVES && !blocked[0] && y_pos != 8'd0) begin
                            y_pos   <= (y_pos < STEP_Y) ? 8'd0 : y_pos - STEP_Y;
                            frame_q <= frame_q + 1'b1;
                        end
                    end
                    3'd3: begin
                        facing <= 2'd1;
                        if (MOVES && !blocked[1] && y_pos < Y_MAX) begin
                            y_pos   <= (y_pos > Y_MAX - STEP_Y) ? Y_MAX : y_pos + STEP_Y;
                            frame_q <= frame_q + 1'b1;
                        end
                    end
                    3'd4: begin
                        facing <= 2'd2;
                        if (MOVES && !blocked[2] && x_pos != 9'd0) begin
                            x_pos   <= (x_pos < STEP_X) ? 9'd0 : x_pos - STEP_X;
                            frame_q <= frame_q + 1'b1;
                        end
                    end
                    3'd5: begin
                        facing <= 2'd3;
                        if (MOVES && !blocked[3] && x_pos < X_MAX) begin
                            x_pos   <= (x_pos > X_MAX - STEP_X) ? X_MAX : x_pos + STEP_X;
                            frame_q <= frame_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ROM address is only driven while fetching so the port idles at zero.
    assign rom_addr_w     = (state_q == FETCH) ? {facing, attacking, frame_eff, pix_q} : '0;
    assign bus.rom_addr   = rom_addr_w;
    assign bus.draw_x     = draw_x_q;
    assign bus.draw_y     = draw_y_q;
    assign bus.draw_color = pix_valid ? bus.rom_data : 6'd0;
    assign bus.draw_we    = pix_valid && (bus.rom_data != TRANSP);
    assign bus.draw_busy  = (state_q != IDLE);
    assign bus.draw_done  = done_q;
endmodule

// File: tb/tb_sprite_actor.sv
// Directed bench for sprite_actor: movement, attack timing, and full sprite
// draws checked pixel by pixel against an expected-pixel queue.
module tb_sprite_actor;
    localparam int         W      = 23;
    localparam logic [5:0] TRANSP = 6'h3F;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic       apply_action = 1'b0;
    logic [2:0] action = 3'd0;
    logic [3:0] blocked = 4'd0;
    logic [8:0] x_pos;
    logic [7:0] y_pos;
    logic [1:0] facing;
    logic       attacking;
    logic [1:0] dbg_state;

    int rom_mode = 0;
    int n_asserts = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    sprite_actor_if #(.ADDR_W(12)) bus ();

    sprite_actor dut (
        .clock        (clock),
        .reset        (reset),
        .init         (init),
        .apply_action (apply_action),
        .action       (action),
        .blocked      (blocked),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .facing       (facing),
        .attacking    (attacking),
        .dbg_state    (dbg_state),
        .bus          (bus)
    );

    // Clock.
    always #5 clock = ~clock;

    // Sprite-sheet colour model; mode 1 makes every even column transparent.
    function automatic logic [5:0] rom_color(input int mode, input logic [11:0] a);
        if (mode == 1 && a[0] == 1'b0) return TRANSP;
        return {1'b0, a[4:0] ^ a[11:7]};
    endfunction

    // Synchronous ROM: colour one cycle after the address.
    always @(posedge clock) bus.rom_data <= rom_color(rom_mode, bus.rom_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pixel scoreboard: every written pixel must be the next expected one.
    always @(negedge clock) begin
        if (bus.draw_we === 1'b1) begin
            check("pix_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("pixel", 32'({bus.draw_x, bus.draw_y, bus.draw_color}), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic apply(input logic [2:0] a);
        action = a;
        apply_action = 1'b1;
        tick();
        apply_action = 1'b0;
    endtask

    task automatic pulse_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic push_draw(input int mode, input logic [8:0] x0, input logic [7:0] y0,
                             input logic [1:0] f, input logic atk, input logic fr);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                logic [11:0] a;
                logic [5:0]  col;
                a   = {f, atk, (atk ? 1'b0 : fr), 4'(r), 4'(c)};
                col = rom_color(mode, a);
                if (col != TRANSP) exp_q.push_back({x0 + 9'(c), y0 + 8'(r), col});
            end
        end
    endtask

    // One draw over a fixed 300-cycle window; cycle c is the c-th cycle after
    // the cycle in which draw_start is high.
    task automatic run_draw(input string tag, input int mode, input logic [8:0] x0,
                            input logic [7:0] y0, input logic [1:0] f, input logic atk,
                            input logic fr, input int exp_first, input int exp_n,
                            input int poke_at, input int abort_at);
        int first_we, done_at, n_we, n_done, n_fetch, busy_at_done;
        logic [8:0] last_x;
        logic [7:0] last_y;
        first_we = -1; done_at = -1; n_we = 0; n_done = 0; n_fetch = 0; busy_at_done = -1;
        last_x = '0; last_y = '0;
        exp_q.delete();
        push_draw(mode, x0, y0, f, atk, fr);
        rom_mode = mode;
        bus.draw_start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            bus.draw_start = 1'b0;
            apply_action = 1'b0;
            reset = 1'b0;
            if (c == 1) check({tag, "_busy_c1"}, 32'(bus.draw_busy), 32'd1);
            if (dbg_state == 2'd1) n_fetch++;
            if (bus.draw_we) begin
                n_we++;
                if (first_we < 0) first_we = c;
                last_x = bus.draw_x;
                last_y = bus.draw_y;
            end
            if (bus.draw_done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = c;
                    busy_at_done = 32'(bus.draw_busy);
                end
            end
            if (abort_at > 0 && c == abort_at + 1) begin
                check({tag, "_abort_busy"}, 32'(bus.draw_busy), 32'd0);
                check({tag, "_abort_we"}, 32'(bus.draw_we), 32'd0);
            end
            if (c == poke_at) begin
                bus.draw_start = 1'b1;
                apply_action = 1'b1;
                action = 3'd5;
            end
            if (c == abort_at) reset = 1'b1;
        end
        if (abort_at > 0) begin
            check({tag, "_abort_no_done"}, 32'(n_done), 32'd0);
            exp_q.delete();
        end else begin
            check({tag, "_first_we_cycle"}, 32'(first_we), 32'(exp_first));
            check({tag, "_done_cycle"}, 32'(done_at), 32'd258);
            check({tag, "_done_count"}, 32'(n_done), 32'd1);
            check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
            check({tag, "_fetch_cycles"}, 32'(n_fetch), 32'd256);
            check({tag, "_we_count"}, 32'(n_we), 32'(exp_n));
            check({tag, "_last_x"}, 32'(last_x), 32'(x0 + 9'd15));
            check({tag, "_last_y"}, 32'(last_y), 32'(y0 + 8'd15));
            check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        bus.draw_start = 1'b0;

        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_x", 32'(x_pos), 32'd127);
        check("rst_y", 32'(y_pos), 32'd88);
        check("rst_facing", 32'(facing), 32'd1);
        check("rst_attacking", 32'(attacking), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_busy", 32'(bus.draw_busy), 32'd0);
        check("rst_we", 32'(bus.draw_we), 32'd0);
        check("rst_done", 32'(bus.draw_done), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_draw_x", 32'(bus.draw_x), 32'd0);
        check("rst_draw_y", 32'(bus.draw_y), 32'd0);
        check("rst_color", 32'(bus.draw_color), 32'd0);

        // Spawn draw.
        pulse_init();
        run_draw("draw_a", 0, 9'd127, 8'd88, 2'd1, 1'b0, 1'b0, 2, 256, 0, 0);

        // Left edge clamp, blocked move still turns the sprite.
        repeat (127) apply(3'd4);
        check("left_edge_x", 32'(x_pos), 32'd0);
        check("left_edge_frame", 32'(dut.frame_q), 32'd1);
        blocked = 4'b1000;
        apply(3'd5);
        check("blocked_right_x", 32'(x_pos), 32'd0);
        check("blocked_right_facing", 32'(facing), 32'd3);
        check("blocked_right_frame", 32'(dut.frame_q), 32'd1);
        blocked = 4'b0000;
        apply(3'd4);
        check("clamp_left_x", 32'(x_pos), 32'd0);
        check("clamp_left_facing", 32'(facing), 32'd2);
        check("clamp_left_frame", 32'(dut.frame_q), 32'd1);

        // Right edge clamp.
        repeat (240) apply(3'd5);
        check("right_edge_x", 32'(x_pos), 32'd240);
        apply(3'd5);
        check("clamp_right_x", 32'(x_pos), 32'd240);
        check("clamp_right_facing", 32'(facing), 32'd3);
        check("clamp_right_frame", 32'(dut.frame_q), 32'd1);

        // No-op actions.
        apply(3'd0);
        apply(3'd6);
        apply(3'd7);
        check("noop_x", 32'(x_pos), 32'd240);
        check("noop_y", 32'(y_pos), 32'd88);
        check("noop_facing", 32'(facing), 32'd3);
        check("noop_attacking", 32'(attacking), 32'd0);
        check("noop_frame", 32'(dut.frame_q), 32'd1);

        // Blocked upward moves, then free ones animating 1,0,1.
        pulse_init();
        check("init_x", 32'(x_pos), 32'd127);
        check("init_frame", 32'(dut.frame_q), 32'd0);
        blocked = 4'b0001;
        repeat (3) apply(3'd2);
        check("blocked_up_y", 32'(y_pos), 32'd88);
        check("blocked_up_facing", 32'(facing), 32'd0);
        check("blocked_up_frame", 32'(dut.frame_q), 32'd0);
        blocked = 4'b0000;
        apply(3'd2);
        check("up1_frame", 32'(dut.frame_q), 32'd1);
        apply(3'd2);
        check("up2_frame", 32'(dut.frame_q), 32'd0);
        apply(3'd2);
        check("up3_frame", 32'(dut.frame_q), 32'd1);
        check("up3_y", 32'(y_pos), 32'd85);

        // Draw facing up on walk frame 1.
        run_draw("draw_b", 0, 9'd127, 8'd85, 2'd0, 1'b0, 1'b1, 2, 256, 0, 0);

        // Attack: frame forced to 0 in the address, actions ignored for 4 pulses.
        pulse_init();
        apply(3'd3);
        check("down_y", 32'(y_pos), 32'd89);
        apply(3'd1);
        check("attack_set", 32'(attacking), 32'd1);
        run_draw("draw_atk", 0, 9'd127, 8'd89, 2'd1, 1'b1, 1'b1, 2, 256, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            apply(3'd5);
            check($sformatf("atk_pulse%0d_x", i), 32'(x_pos), 32'd127);
            check($sformatf("atk_pulse%0d_attacking", i), 32'(attacking), (i < 4) ? 32'd1 : 32'd0);
        end
        check("atk_facing_kept", 32'(facing), 32'd1);
        apply(3'd5);
        check("post_atk_x", 32'(x_pos), 32'd128);
        check("post_atk_facing", 32'(facing), 32'd3);
        check("post_atk_frame", 32'(dut.frame_q), 32'd0);

        // Transparent columns, ignored mid-draw start and action.
        pulse_init();
        run_draw("draw_c", 1, 9'd127, 8'd88, 2'd1, 1'b0, 1'b0, 3, 128, 50, 0);
        check("middraw_x", 32'(x_pos), 32'd127);
        check("middraw_facing", 32'(facing), 32'd1);

        // Reset mid-draw, then a clean redraw.
        pulse_init();
        run_draw("draw_d", 0, 9'd127, 8'd88, 2'd1, 1'b0, 1'b0, 2, 256, 0, 101);
        run_draw("draw_e", 0, 9'd127, 8'd88, 2'd1, 1'b0, 1'b0, 2, 256, 0, 0);

        // init beats apply_action and draw_start.
        init = 1'b1;
        apply_action = 1'b1;
        action = 3'd5;
        tick();
        init = 1'b0;
        apply_action = 1'b0;
        check("init_vs_apply_x", 32'(x_pos), 32'd127);
        check("init_vs_apply_facing", 32'(facing), 32'd1);
        init = 1'b1;
        bus.draw_start = 1'b1;
        tick();
        init = 1'b0;
        bus.draw_start = 1'b0;
        check("init_vs_draw_busy", 32'(bus.draw_busy), 32'd0);
        tick();
        check("init_vs_draw_busy2", 32'(bus.draw_busy), 32'd0);
        check("init_vs_draw_state", 32'(dbg_state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_actor.md
SPRITE_ACTOR -- requirements
Module: sprite_actor

Interface
REQ-001 SHALL have parameter SPR_W, 16, sprite width in pixels (power of 2).
REQ-002 SHALL have parameter SPR_H, 16, sprite height in pixels (power of 2).
REQ-003 SHALL have parameter MAP_W, 256, map width in pixels; x_pos max = MAP_W-SPR_W.
REQ-004 SHALL have parameter MAP_H, 176, map height in pixels; y_pos max = MAP_H-SPR_H.
REQ-005 SHALL have parameter STEP, 1, pixels moved per accepted move action.
REQ-006 SHALL have parameter N_FRAMES, 2, walk animation frames per direction (power of 2).
REQ-007 SHALL have parameter ATK_LEN, 4, apply_action pulses an attack lasts.
REQ-008 SHALL have parameter INIT_X, 127, and INIT_Y, 88, as the spawn position.
REQ-009 SHALL have parameter TRANSP, 6'h3F, as the transparent colour code.
REQ-010 SHALL have the ports: clock input 1, system clock; reset input 1, synchronous active-high reset.
REQ-011 SHALL have the ports: init input 1, spawn pulse; apply_action input 1, action-sample pulse; draw_start input 1, draw request pulse.
REQ-012 SHALL have the ports: action input 3, 0 none / 1 attack / 2 up / 3 down / 4 left / 5 right / 6-7 none; blocked input 4, collision flags {right,left,down,up}.
REQ-013 SHALL have the ports: rom_addr output log2(SPR_W*SPR_H*4*2*N_FRAMES), sprite-sheet address; rom_data input 6, colour returned one cycle after rom_addr.
REQ-014 SHALL have the ports: x_pos output 9, y_pos output 8, facing output 2 (0 up / 1 down / 2 left / 3 right), attacking output 1.
REQ-015 SHALL have the ports: draw_x output 9, draw_y output 8, draw_color output 6, draw_we output 1, draw_busy output 1, draw_done output 1.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH and FLUSH; reset and init SHALL force IDLE.
REQ-017 IDLE + draw_start SHALL go to FETCH with pixel counter 0 and draw_busy=1 from the next cycle.
REQ-018 FETCH SHALL issue one rom_addr per cycle in raster order (col fastest, then row), SPR_W*SPR_H addresses in total, then go to FLUSH.
REQ-019 FLUSH SHALL last one cycle to capture the final rom_data; it SHALL pulse draw_done for one cycle, clear draw_busy and return to IDLE.
REQ-020 Address composition SHALL be {facing, attacking, frame, row, col}, with frame forced to 0 while attacking.
REQ-021 Pixel output SHALL be registered: the output for address k SHALL appear exactly 1 cycle after it issues; draw_x = x_pos+col and draw_y = y_pos+row, latched at draw_start.
REQ-022 draw_we SHALL be 1 only for a valid pixel with rom_data != TRANSP; draw_color SHALL equal rom_data.
REQ-023 draw_start SHALL be ignored when not in IDLE; apply_action while draw_busy=1 SHALL be ignored (position frozen during draw).
REQ-024 For a move action on apply_action, facing SHALL update even if the move is blocked or clamped.
REQ-025 For a move action, position SHALL change by STEP unless the matching blocked bit is 1; the result SHALL saturate at 0 and at the maximum, with no wrap-around.
REQ-026 Each accepted non-zero move SHALL advance frame modulo N_FRAMES; a blocked or zero-distance move SHALL NOT advance it.
REQ-027 An attack action when attacking=0 SHALL set attacking=1 with an attack counter of ATK_LEN.
REQ-028 While attacking, each apply_action SHALL decrement the counter, ignore all actions, and clear attacking when the counter reaches 0.
REQ-029 Actions 0, 6 and 7 SHALL change nothing.
REQ-030 If init and apply_action are both high, init SHALL win; if init and draw_start are both high, init SHALL win and no draw SHALL start.

Reset
REQ-031 Reset or init SHALL set: x_pos=INIT_X, y_pos=INIT_Y, facing=1, attacking=0, frame=0, attack counter=0.
REQ-032 Reset or init SHALL set: draw_we=0, draw_busy=0, draw_done=0, rom_addr=0, draw_x=0, draw_y=0, draw_color=0.
REQ-033 Reset or init asserted mid-draw SHALL abort the draw; no draw_done SHALL be issued for the aborted draw.

Verification
REQ-034 Defaults, init, then draw_start with ROM returning address-derived colour -> 256 addresses, first draw_we at cycle 2 with draw_x=127 and draw_y=88, the last pixel at (142,103), and draw_done at cycle 258.
REQ-035 x_pos=0, action=left -> x_pos stays 0, facing=2, frame unchanged; x_pos=240, action=right -> x_pos stays 240.
REQ-036 blocked=4'b0001, action=up x3 -> y_pos=88, facing=0; then blocked=0, up x3 -> y_pos=85, frame sequence 1,0,1.
REQ-037 Attack then 4 apply_action pulses with action=right -> x_pos unchanged, attacking=1 through 3 pulses and 0 after the 4th; the next right moves to 128.
REQ-038 ROM returning TRANSP for even col -> exactly 128 draw_we pulses; a draw_start mid-draw is ignored; apply_action mid-draw leaves position unchanged.
REQ-039 Reset asserted at pixel 100 -> draw_busy=0 and draw_we=0 next cycle, no draw_done, and a new draw_start behaves per REQ-034.
